// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin, packet-locked arbiter sharing one UART transmitter.
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int P_NUM_REQ   = 4,
  parameter int P_NUM_BITS  = 8,
  parameter int P_MAX_BURST = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [P_NUM_REQ*P_NUM_BITS-1:0]   req_data_i,
  input  logic [P_NUM_REQ-1:0]              req_vld_i,
  input  logic [P_NUM_REQ-1:0]              req_last_i,
  output logic [P_NUM_REQ-1:0]              req_rdy_o,
  output logic [P_NUM_BITS-1:0]             data_out_o,
  output logic                              data_out_vld_o,
  input  logic                              data_out_rdy_i,
  output logic [P_NUM_REQ-1:0]              grant_o,
  output logic                              busy_o
);

  localparam int c_IDX_W  = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam int c_SUM_W  = c_IDX_W + 1;
  localparam int c_CNT_W  = (P_MAX_BURST > 0) ? $clog2(P_MAX_BURST + 1) : 1;
  localparam int c_CAP_M1 = (P_MAX_BURST > 0) ? P_MAX_BURST - 1 : 0;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t               state_q;
  logic [P_NUM_REQ-1:0] grant_q;
  logic [c_IDX_W-1:0]   owner_q;
  logic [c_IDX_W-1:0]   last_gnt_q;
  logic [c_CNT_W-1:0]   cnt_q;

  logic [c_SUM_W-1:0]   w_sum;
  logic [c_IDX_W-1:0]   w_sel;
  logic [P_NUM_REQ-1:0] w_sel_oh;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_cap_hit;

  // Walk from the farthest candidate to the nearest so the nearest requester
  // after last_gnt (modulo P_NUM_REQ) is the one left in w_sel.
  always_comb begin
    w_sel = '0;
    w_sum = '0;
    for (int k = P_NUM_REQ; k >= 1; k--) begin
      w_sum = {1'b0, last_gnt_q} + c_SUM_W'(k);
      if (w_sum >= c_SUM_W'(P_NUM_REQ)) w_sum = w_sum - c_SUM_W'(P_NUM_REQ);
      if (req_vld_i[w_sum[c_IDX_W-1:0]]) w_sel = w_sum[c_IDX_W-1:0];
    end
  end

  assign w_sel_oh = P_NUM_REQ'(1) << w_sel;

  always_comb begin
    data_out_o = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (grant_q[i]) data_out_o = req_data_i[i*P_NUM_BITS +: P_NUM_BITS];
    end
  end

  assign data_out_vld_o = |(req_vld_i & grant_q);
  assign req_rdy_o      = grant_q & {P_NUM_REQ{data_out_rdy_i}};
  assign grant_o        = grant_q;
  assign busy_o         = (state_q == S_BURST);

  assign w_xfer    = data_out_vld_o && data_out_rdy_i;
  assign w_last    = |(req_last_i & grant_q);
  assign w_cap_hit = (P_MAX_BURST > 0) && (cnt_q == c_CNT_W'(c_CAP_M1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      last_gnt_q <= c_IDX_W'(P_NUM_REQ - 1);
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req_vld_i) begin
            grant_q <= w_sel_oh;
            owner_q <= w_sel;
            cnt_q   <= '0;
            state_q <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_xfer) begin
            if (w_last || w_cap_hit) begin
              last_gnt_q <= owner_q;
              grant_q    <= '0;
              state_q    <= S_IDLE;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
